// File: rtl/d16_pkg.sv
// Shared definitions for the d16 decode stage: opcodes, instruction fields, widths,
// and the decoded-op record carried by the output register.
package d16_pkg;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int NREG  = 16;

  localparam int OP_LO = 12;
  localparam int RD_LO = 8;
  localparam int RA_LO = 4;
  localparam int RB_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_LDI   = 4'h8,
    OP_LD    = 4'h9,
    OP_ST    = 4'hA,
    OP_RSV_B = 4'hB,
    OP_RSV_C = 4'hC,
    OP_RSV_D = 4'hD,
    OP_RSV_E = 4'hE,
    OP_HALT  = 4'hF
  } op_e;

  typedef enum logic {ST_RUN, ST_HALTED} state_e;

  typedef struct packed {
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic          we;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } dec_t;

endpackage

// File: rtl/d16_scoreboard.sv
// Pending-write mask: one bit per register, set when a writing op issues, cleared by
// the write-back bus. A set on the same register in the same cycle wins over the clear.
module d16_scoreboard
  import d16_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic [AW-1:0] look_a,
  input  logic [AW-1:0] look_b,
  output logic          pend_a,
  output logic          pend_b
);

  logic [NREG-1:0] sb, sb_nxt;

  always_comb begin
    sb_nxt = sb;
    if (clr_en) sb_nxt[clr_addr] = 1'b0;
    if (set_en) sb_nxt[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= sb_nxt;
  end

  assign pend_a = sb[look_a];
  assign pend_b = sb[look_b];

endmodule

// File: rtl/d16_decode.sv
// Decode / operand-fetch stage in front of d16_registers, with RAW stall scoreboard.
// Optional write-back forwarding: define D16_DECODE_BYPASS_EN.
module d16_decode
  import d16_pkg::*;
#(
  parameter int NREG = 16,
  parameter int DW   = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          instr_valid,
  input  logic [DW-1:0] instr,
  output logic          instr_ready,
  output logic [3:0]    addr_a,
  output logic [3:0]    addr_b,
  input  logic [DW-1:0] qa,
  input  logic [DW-1:0] qb,
  input  logic          wb_valid,
  input  logic [3:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_op,
  output logic [3:0]    out_rd,
  output logic          out_we,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b
  ,output logic         illegal,
  output logic          halted
);

  op_e           op;
  logic [AW-1:0] rd, ra, rb;
  logic [7:0]    imm8;
  logic          uses_ra, uses_rb, we, rsv, is_halt;
  logic          pend_a, pend_b, fwd_a, fwd_b, hazard, accept;
  logic [DW-1:0] opa, opb;
  dec_t          dec, out_q;
  state_e        state_q, state_d;

  assign op   = op_e'(instr[OP_LO +: 4]);
  assign rd   = instr[RD_LO +: AW];
  assign ra   = instr[RA_LO +: AW];
  assign rb   = instr[RB_LO +: AW];
  assign imm8 = instr[7:0];

  assign addr_a = ra;
  assign addr_b = rb;

  always_comb begin
    uses_ra = 1'b0;
    uses_rb = 1'b0;
    we      = 1'b0;
    rsv     = 1'b0;
    is_halt = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SHL, OP_SHR: begin uses_ra = 1'b1; uses_rb = 1'b1; we = 1'b1; end
      OP_LDI:                 we = 1'b1;
      OP_LD:                  begin uses_ra = 1'b1; we = 1'b1; end
      OP_ST:                  begin uses_ra = 1'b1; uses_rb = 1'b1; end
      OP_RSV_B, OP_RSV_C,
      OP_RSV_D, OP_RSV_E:     rsv = 1'b1;
      OP_HALT:                is_halt = 1'b1;
      default:                ;
    endcase
  end

  // Forwarding covers the cycle where the register file has not yet taken the write.
`ifdef D16_DECODE_BYPASS_EN
  assign fwd_a = wb_valid && (wb_addr == ra);
  assign fwd_b = wb_valid && (wb_addr == rb);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign opa = fwd_a ? wb_data : qa;
  assign opb = fwd_b ? wb_data : qb;

  assign hazard      = (uses_ra & pend_a & ~fwd_a) | (uses_rb & pend_b & ~fwd_b);
  assign instr_ready = (state_q == ST_RUN) & (~out_valid | out_ready) & ~hazard;
  assign accept      = instr_valid & instr_ready;

  d16_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .set_en   (accept & we),
    .set_addr (rd),
    .look_a   (ra),
    .look_b   (rb),
    .pend_a   (pend_a),
    .pend_b   (pend_b)
  );

  // Reserved opcodes leave as a clean NOP; unused operand slots are zeroed.
  always_comb begin
    dec    = '0;
    dec.op = rsv ? 4'(OP_NOP) : 4'(op);
    dec.rd = rsv ? '0 : rd;
    dec.we = we;
    dec.a  = uses_ra ? opa : '0;
    if (op == OP_LDI)  dec.b = {{(DW-8){1'b0}}, imm8};
    else if (uses_rb)  dec.b = opb;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      illegal <= accept & rsv;
      if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && accept && is_halt) state_d = ST_HALTED;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  assign halted = (state_q == ST_HALTED);
  assign out_op = out_q.op;
  assign out_rd = out_q.rd;
  assign out_we = out_q.we;
  assign out_a  = out_q.a;
  assign out_b  = out_q.b;

endmodule

// File: tb/tb_d16_decode.sv
// Directed bench for d16_decode with a behavioural register file on the write-back bus.
// Expectations follow D16_DECODE_BYPASS_EN when it is defined.
module tb_d16_decode;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] qa, qb;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_op, out_rd;
  logic        out_we;
  logic [15:0] out_a, out_b;
  logic        illegal, halted;

  int checks   = 0;
  int failures = 0;

  logic [15:0] rf [16];

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (wb_valid) rf[wb_addr] <= wb_data;
  assign qa = rf[addr_a];
  assign qb = rf[addr_b];

  d16_decode dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .qa          (qa),
    .qb          (qb),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_a       (out_a),
    .out_b       (out_b),
    .illegal     (illegal),
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wb(input logic v, input logic [3:0] a, input logic [15:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  initial begin
    sys_rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000; out_ready = 1'b1;
    // preload r1=5, r2=7 through the write-back bus while in reset
    wb(1'b1, 4'd1, 16'd5);
    tick();
    wb(1'b1, 4'd2, 16'd7);
    tick();
    wb(1'b0, 4'd0, 16'd0);
    sys_rst = 1'b0;
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_op", 16'(out_op), 16'd0);
    chk("rst_out_a", out_a, 16'd0);
    chk("rst_out_b", out_b, 16'd0);
    chk("rst_illegal", 16'(illegal), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_ready", 16'(instr_ready), 16'd1);

    // ADD r3,r1,r2
    instr_valid = 1'b1; instr = 16'h1312;
    #1;
    chk("add_ready", 16'(instr_ready), 16'd1);
    chk("add_addr_a", 16'(addr_a), 16'd1);
    chk("add_addr_b", 16'(addr_b), 16'd2);
    tick();
    chk("add_valid", 16'(out_valid), 16'd1);
    chk("add_op", 16'(out_op), 16'd1);
    chk("add_rd", 16'(out_rd), 16'd3);
    chk("add_we", 16'(out_we), 16'd1);
    chk("add_a", out_a, 16'd5);
    chk("add_b", out_b, 16'd7);

    // SUB r4,r3,r1 stalls on r3
    instr = 16'h2431;
    #1;
    chk("sub_stall0", 16'(instr_ready), 16'd0);
    tick();
    chk("sub_drain_valid", 16'(out_valid), 16'd0);
    chk("sub_stall1", 16'(instr_ready), 16'd0);
    wb(1'b1, 4'd3, 16'd12);
    #1;
`ifdef D16_DECODE_BYPASS_EN
    chk("sub_wb_ready", 16'(instr_ready), 16'd1);
`else
    chk("sub_wb_ready", 16'(instr_ready), 16'd0);
`endif
    tick();
    wb(1'b0, 4'd0, 16'd0);
`ifndef D16_DECODE_BYPASS_EN
    #1;
    chk("sub_after_wb_ready", 16'(instr_ready), 16'd1);
    tick();
`endif
    chk("sub_valid", 16'(out_valid), 16'd1);
    chk("sub_op", 16'(out_op), 16'd2);
    chk("sub_rd", 16'(out_rd), 16'd4);
    chk("sub_a", out_a, 16'd12);
    chk("sub_b", out_b, 16'd5);

    // backpressure: SUB held for 3 cycles, ADD r5,r1,r2 waits
    out_ready = 1'b0; instr = 16'h1512;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 16'(instr_ready), 16'd0);
      chk("bp_valid", 16'(out_valid), 16'd1);
      chk("bp_op", 16'(out_op), 16'd2);
      chk("bp_rd", 16'(out_rd), 16'd4);
      chk("bp_a", out_a, 16'd12);
      chk("bp_b", out_b, 16'd5);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 16'(instr_ready), 16'd1);
    tick();
    chk("bp_next_op", 16'(out_op), 16'd1);
    chk("bp_next_rd", 16'(out_rd), 16'd5);
    chk("bp_next_a", out_a, 16'd5);
    chk("bp_next_b", out_b, 16'd7);

    // LDI r10 then LDI r2,0xA5 with r10 and r5 pending
    instr = 16'h8A11;
    #1;
    chk("ldi10_ready", 16'(instr_ready), 16'd1);
    tick();
    instr = 16'h82A5;
    #1;
    chk("ldi2_ready", 16'(instr_ready), 16'd1);
    tick();
    chk("ldi2_op", 16'(out_op), 16'd8);
    chk("ldi2_rd", 16'(out_rd), 16'd2);
    chk("ldi2_we", 16'(out_we), 16'd1);
    chk("ldi2_b", out_b, 16'h00A5);
    instr = 16'h1620;
    #1;
    chk("sb2_stall", 16'(instr_ready), 16'd0);
    instr_valid = 1'b0;
    wb(1'b1, 4'd2, 16'h00A5);
    tick();

    // ADD r5,r1,r2 issued in the same cycle r5 is written back
    instr_valid = 1'b1; instr = 16'h1512;
    wb(1'b1, 4'd5, 16'd99);
    #1;
    chk("setclr_ready", 16'(instr_ready), 16'd1);
    tick();
    wb(1'b0, 4'd0, 16'd0);
    instr = 16'hA050;
    #1;
    chk("sb5_kept", 16'(instr_ready), 16'd0);
    instr = 16'hA0A0;
    #1;
    chk("sb10_kept", 16'(instr_ready), 16'd0);

    // reserved opcode
    instr = 16'hC123;
    #1;
    chk("rsv_ready", 16'(instr_ready), 16'd1);
    tick();
    instr_valid = 1'b0;
    chk("rsv_valid", 16'(out_valid), 16'd1);
    chk("rsv_illegal", 16'(illegal), 16'd1);
    chk("rsv_op", 16'(out_op), 16'd0);
    chk("rsv_we", 16'(out_we), 16'd0);
    tick();
    chk("rsv_illegal_drop", 16'(illegal), 16'd0);
    chk("rsv_valid_drop", 16'(out_valid), 16'd0);

    // HALT
    instr_valid = 1'b1; instr = 16'hF000;
    #1;
    chk("halt_ready", 16'(instr_ready), 16'd1);
    tick();
    chk("halt_halted", 16'(halted), 16'd1);
    chk("halt_op", 16'(out_op), 16'hF);
    chk("halt_we", 16'(out_we), 16'd0);
    instr = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("halted_ready", 16'(instr_ready), 16'd0);
      chk("halted_flag", 16'(halted), 16'd1);
      tick();
    end
    chk("halted_drained", 16'(out_valid), 16'd0);

    // one-cycle reset leaves HALTED and clears the scoreboard
    instr_valid = 1'b0;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    #1;
    chk("rst2_halted", 16'(halted), 16'd0);
    chk("rst2_valid", 16'(out_valid), 16'd0);
    chk("rst2_op", 16'(out_op), 16'd0);
    instr_valid = 1'b1; instr = 16'hA050;
    #1;
    chk("rst2_sb5_clear", 16'(instr_ready), 16'd1);
    instr = 16'hA0A0;
    #1;
    chk("rst2_sb10_clear", 16'(instr_ready), 16'd1);
    instr_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
